decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage with a valid/ready handshake on both sides.
- Sits between the fetch stage and the register-read/execute stage.
- Generalises the combinational field decoder in three ways:
  - parametrised XLEN;
  - one pre-selected, sign-extended immediate instead of five parallel immediates;
  - register-usage flags, a 2-entry skid buffer and flush.

Parameters:
- XLEN, 32, datapath and immediate width; legal values 32 or 64.
- PC_W, 32, program-counter width carried alongside the instruction.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; driven from a register.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  consumer accepts.
- out_pc  out  PC_W  address of the decoded instruction.
- out_op  out  10  one-hot class: [0] ALUReg, [1] ALUImm, [2] Branch, [3] JALR, [4] JAL, [5] AUIPC, [6] LUI, [7] Load, [8] Store, [9] System.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_funct3  out  3.
- out_funct7  out  7.
- out_imm  out  XLEN  selected immediate, sign-extended.
- out_rs1_used, out_rs2_used, out_rd_wr  out  1 each  operand-usage flags.
- out_illegal  out  1  illegal-encoding flag.

Behaviour:
- Reset: all outputs 0 except in_ready=1; both entries invalid.
- Latency: accepted instruction appears at the outputs on the next cycle. Throughput is 1/cycle while out_ready=1.
- Accept condition: in_valid & in_ready. Output transfer condition: out_valid & out_ready.
- Main/skid buffer:
  - Main register drives the outputs.
  - If main is full and not transferring when an accept occurs, the decoded entry goes to the skid register.
  - in_ready = !skid_valid, registered.
  - When main drains, skid moves to main on the same edge.
  - Order is always preserved.
- Simultaneous accept and transfer with skid empty: the new entry replaces main; out_valid stays 1.
- Flush:
  - Both entries are invalidated next edge; in_ready=1 next cycle.
  - An accept in the same cycle is dropped (flush has priority).
  - out_valid deasserts the cycle after flush.
- Reset mid-transfer: immediate clear; no entry survives.
- Decode:
  - Opcode is instr[6:0]; class bits are exact opcode matches.
  - Unknown opcode gives out_op=0.
  - rs1/rs2/rd/funct3/funct7 are fixed bit slices, captured unconditionally.
- Immediate select, built at 32 bits then sign-extended from bit 31 to XLEN:
  - I-type: ALUImm, Load, JALR.
  - S-type: Store.
  - B-type: Branch, bit 0 = 0.
  - U-type: LUI, AUIPC, low 12 bits 0.
  - J-type: JAL, bit 0 = 0.
  - Otherwise 0.
- Usage flags:
  - rs1_used: ALUReg, ALUImm, Branch, JALR, Load, Store.
  - rs2_used: ALUReg, Branch, Store.
  - rd_wr: ALUReg, ALUImm, JALR, JAL, AUIPC, LUI, Load, and only when rd != 0.
- out_* fields hold stable while out_valid & !out_ready.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- With the macro, out_illegal=1 when any of these holds:
  - instr[1:0] != 2'b11;
  - unknown opcode;
  - ALUReg funct7 is neither 0000000 nor 0100000;
  - ALUReg funct7=0100000 with funct3 not in {000, 101};
  - Branch funct3 in {010, 011};
  - JALR funct3 != 000;
  - Load funct3 in {011, 110, 111} when XLEN=32, or 111 when XLEN=64;
  - Store funct3 > 010 when XLEN=32, or > 011 when XLEN=64;
  - ALUImm shift with an illegal funct7.
- When illegal, out_rd_wr is forced to 0; the entry still flows normally.
- Without the macro: out_illegal is tied to 0 and no check logic is generated.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - op-class index constants (OP_ALUREG..OP_SYSTEM);
  - immediate-format select enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE);
  - the decoded-entry struct used for both the main and skid registers.
- Sub-module decode_comb is pure combinational instruction-to-entry decode, parametrised by XLEN. decode_stage owns only the handshake and the two registers.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1: out_op[1]=1, rd=1, imm=0xFFFFFFFF (0xFFFFFFFFFFFFFFFF at XLEN=64), rd_wr=1, rs2_used=0; output one cycle after accept.
- beq x0,x0,-4 (0xFE000EE3): out_op[2]=1, imm=0xFFFFFFFC, rs1_used=rs2_used=1, rd_wr=0.
- lui x5,0x12345 (0x123452B7): imm=0x12345000, rd=5; addi x0,x0,0 (0x00000013): rd_wr=0.
- Backpressure, out_ready=0, three back-to-back valid instructions:
  - first two accepted; in_ready=0 from the cycle after the second accept;
  - release out_ready: order is A, B, then C accepted, with no loss or duplication.
- Flush with skid full plus a concurrent in_valid: next cycle out_valid=0, in_ready=1; the concurrent instruction never appears.
- With DECODE_ILLEGAL_CHECK_EN, instr 0x00000000 gives out_illegal=1, rd_wr=0; sub with funct7=0x21 is illegal. Without the macro, both give out_illegal=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcodes, op-class indices, immediate formats and the decoded-entry
// fields for the decode_stage pipeline slice.
package decode_pkg;

    localparam logic [6:0] OPC_ALUREG = 7'b0110011;
    localparam logic [6:0] OPC_ALUIMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int OP_ALUREG = 0;
    localparam int OP_ALUIMM = 1;
    localparam int OP_BRANCH = 2;
    localparam int OP_JALR   = 3;
    localparam int OP_JAL    = 4;
    localparam int OP_AUIPC  = 5;
    localparam int OP_LUI    = 6;
    localparam int OP_LOAD   = 7;
    localparam int OP_STORE  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int NUM_OP    = 10;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    // Width-independent part of a decoded entry; imm and pc ride alongside.
    typedef struct packed {
        logic [NUM_OP-1:0] op;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic              rs1_used;
        logic              rs2_used;
        logic              rd_wr;
        logic              illegal;
    } decode_fields_t;

    function automatic logic [31:0] imm_build(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and consumer-side handshake bundle of decode_stage.
// master = surrounding pipeline, slave = the decode stage itself.
interface decode_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [9:0]      out_op;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_rd_wr;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_rs1_used, out_rs2_used,
               out_rd_wr, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_rs1_used, out_rs2_used,
               out_rd_wr, out_illegal
    );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV32I/RV64I instruction-to-entry decode.
// Illegal-encoding checks are built only when DECODE_ILLEGAL_CHECK_EN is defined.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output decode_fields_t  fields,
    output logic [XLEN-1:0] imm
);

    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [6:0]        funct7_s;
    logic [NUM_OP-1:0] op_s;
    imm_fmt_e          fmt_s;
    logic [31:0]       imm32_s;
    logic              illegal_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];

    // Opcode to one-hot class and immediate format.
    always_comb begin
        op_s  = '0;
        fmt_s = IMM_NONE;
        case (opcode_s)
            OPC_ALUREG: op_s[OP_ALUREG] = 1'b1;
            OPC_ALUIMM: begin op_s[OP_ALUIMM] = 1'b1; fmt_s = IMM_I; end
            OPC_BRANCH: begin op_s[OP_BRANCH] = 1'b1; fmt_s = IMM_B; end
            OPC_JALR:   begin op_s[OP_JALR]   = 1'b1; fmt_s = IMM_I; end
            OPC_JAL:    begin op_s[OP_JAL]    = 1'b1; fmt_s = IMM_J; end
            OPC_AUIPC:  begin op_s[OP_AUIPC]  = 1'b1; fmt_s = IMM_U; end
            OPC_LUI:    begin op_s[OP_LUI]    = 1'b1; fmt_s = IMM_U; end
            OPC_LOAD:   begin op_s[OP_LOAD]   = 1'b1; fmt_s = IMM_I; end
            OPC_STORE:  begin op_s[OP_STORE]  = 1'b1; fmt_s = IMM_S; end
            OPC_SYSTEM: op_s[OP_SYSTEM] = 1'b1;
            default:    op_s = '0;
        endcase
    end

    assign imm32_s = imm_build(instr, fmt_s);
    assign imm     = XLEN'($signed(imm32_s));

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Encoding legality; RV64 shifts use a 6-bit shamt so only funct6 is checked.
    always_comb begin
        illegal_s = 1'b0;
        if ((instr[1:0] != 2'b11) || (op_s == '0)) begin
            illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_ALUREG: illegal_s = !((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000))
                                     || ((funct7_s == 7'b0100000) && !((funct3_s == 3'b000) || (funct3_s == 3'b101)));
                OPC_BRANCH: illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
                OPC_JALR:   illegal_s = (funct3_s != 3'b000);
                OPC_LOAD:   illegal_s = (XLEN == 32) ? ((funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11))
                                                     : (funct3_s == 3'b111);
                OPC_STORE:  illegal_s = (XLEN == 32) ? (funct3_s > 3'b010) : (funct3_s > 3'b011);
                OPC_ALUIMM: begin
                    if (funct3_s == 3'b001) begin
                        illegal_s = (XLEN == 32) ? (funct7_s != 7'b0000000) : (instr[31:26] != 6'b000000);
                    end else if (funct3_s == 3'b101) begin
                        illegal_s = (XLEN == 32) ? !((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000))
                                                 : !((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000));
                    end else begin
                        illegal_s = 1'b0;
                    end
                end
                default:    illegal_s = 1'b0;
            endcase
        end
    end
`else
    assign illegal_s = 1'b0;
`endif

    // Field slices and operand-usage flags.
    always_comb begin
        fields.op       = op_s;
        fields.rs1      = instr[19:15];
        fields.rs2      = instr[24:20];
        fields.rd       = instr[11:7];
        fields.funct3   = funct3_s;
        fields.funct7   = funct7_s;
        fields.rs1_used = op_s[OP_ALUREG] | op_s[OP_ALUIMM] | op_s[OP_BRANCH]
                        | op_s[OP_JALR] | op_s[OP_LOAD] | op_s[OP_STORE];
        fields.rs2_used = op_s[OP_ALUREG] | op_s[OP_BRANCH] | op_s[OP_STORE];
        fields.rd_wr    = (op_s[OP_ALUREG] | op_s[OP_ALUIMM] | op_s[OP_JALR] | op_s[OP_JAL]
                        | op_s[OP_AUIPC] | op_s[OP_LUI] | op_s[OP_LOAD])
                        & (instr[11:7] != 5'd0) & ~illegal_s;
        fields.illegal  = illegal_s;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main output register plus a one-entry skid buffer,
// valid/ready on both sides, synchronous flush. Honours DECODE_ILLEGAL_CHECK_EN via decode_comb.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic    clk,
    input  logic    reset,
    decode_if.slave bus
);

    typedef struct packed {
        decode_fields_t  f;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
    } entry_t;

    decode_fields_t  dec_fields_s;
    logic [XLEN-1:0] dec_imm_s;
    entry_t          dec_s;
    entry_t          main_r, skid_r, main_nxt_s, skid_nxt_s;
    logic            main_valid_r, skid_valid_r, in_ready_r;
    logic            main_valid_nxt_s, skid_valid_nxt_s;
    logic            accept_s, xfer_s;

    decode_comb #(.XLEN(XLEN)) u_comb (
        .instr  (bus.in_instr),
        .fields (dec_fields_s),
        .imm    (dec_imm_s)
    );

    assign dec_s    = {dec_fields_s, dec_imm_s, bus.in_pc};
    assign accept_s = bus.in_valid & in_ready_r;
    assign xfer_s   = main_valid_r & bus.out_ready;

    // Next state of both entries; skid is always older than a fresh accept.
    always_comb begin
        main_nxt_s       = main_r;
        skid_nxt_s       = skid_r;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (bus.flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (!main_valid_r || xfer_s) begin
            if (skid_valid_r) begin
                main_nxt_s       = skid_r;
                main_valid_nxt_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                main_nxt_s       = dec_s;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else if (accept_s) begin
            skid_nxt_s       = dec_s;
            skid_valid_nxt_s = 1'b1;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Entry registers and registered in_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_r       <= main_nxt_s;
            skid_r       <= skid_nxt_s;
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = main_valid_r;
    assign bus.out_pc       = main_r.pc;
    assign bus.out_op       = main_r.f.op;
    assign bus.out_rs1      = main_r.f.rs1;
    assign bus.out_rs2      = main_r.f.rs2;
    assign bus.out_rd       = main_r.f.rd;
    assign bus.out_funct3   = main_r.f.funct3;
    assign bus.out_funct7   = main_r.f.funct7;
    assign bus.out_imm      = main_r.imm;
    assign bus.out_rs1_used = main_r.f.rs1_used;
    assign bus.out_rs2_used = main_r.f.rs2_used;
    assign bus.out_rd_wr    = main_r.f.rd_wr;
    assign bus.out_illegal  = main_r.f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-decoded instruction table, expected
// entries queued on accept and compared on transfer. Expectations follow DECODE_ILLEGAL_CHECK_EN.
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int NV   = 14;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [9:0]      op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic            rs1u;
        logic            rs2u;
        logic            rdwr;
        logic            ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();
    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] v_instr [NV];
    logic [9:0]  v_op    [NV];
    logic [31:0] v_imm   [NV];
    logic [2:0]  v_use   [NV];   // {rs1_used, rs2_used, rd_wr ignoring the illegal check}
    logic        v_ill   [NV];   // illegal when the check is built

    exp_t            sb_q[$];
    exp_t            cur_exp;
    logic [PC_W-1:0] next_pc = 32'h0000_1000;
    logic            last_acc;
    int              total = 0;
    int              bad = 0;
    int              pops = 0;

    task automatic load_table();
        v_instr[0]  = 32'hFFF00093; v_op[0]  = 10'h002; v_imm[0]  = 32'hFFFFFFFF; v_use[0]  = 3'b101; // addi x1,x0,-1
        v_instr[1]  = 32'hFE000EE3; v_op[1]  = 10'h004; v_imm[1]  = 32'hFFFFFFFC; v_use[1]  = 3'b110; // beq x0,x0,-4
        v_instr[2]  = 32'h123452B7; v_op[2]  = 10'h040; v_imm[2]  = 32'h12345000; v_use[2]  = 3'b001; // lui x5
        v_instr[3]  = 32'h00000013; v_op[3]  = 10'h002; v_imm[3]  = 32'h00000000; v_use[3]  = 3'b100; // nop
        v_instr[4]  = 32'h002081B3; v_op[4]  = 10'h001; v_imm[4]  = 32'h00000000; v_use[4]  = 3'b111; // add x3,x1,x2
        v_instr[5]  = 32'h0020A423; v_op[5]  = 10'h100; v_imm[5]  = 32'h00000008; v_use[5]  = 3'b110; // sw x2,8(x1)
        v_instr[6]  = 32'hFF012203; v_op[6]  = 10'h080; v_imm[6]  = 32'hFFFFFFF0; v_use[6]  = 3'b101; // lw x4,-16(x2)
        v_instr[7]  = 32'hFF9FF0EF; v_op[7]  = 10'h010; v_imm[7]  = 32'hFFFFFFF8; v_use[7]  = 3'b001; // jal x1,-8
        v_instr[8]  = 32'h00008067; v_op[8]  = 10'h008; v_imm[8]  = 32'h00000000; v_use[8]  = 3'b100; // jalr x0,0(x1)
        v_instr[9]  = 32'hFFFFF397; v_op[9]  = 10'h020; v_imm[9]  = 32'hFFFFF000; v_use[9]  = 3'b001; // auipc x7
        v_instr[10] = 32'h00000073; v_op[10] = 10'h200; v_imm[10] = 32'h00000000; v_use[10] = 3'b000; // ecall
        v_instr[11] = 32'h00000000; v_op[11] = 10'h000; v_imm[11] = 32'h00000000; v_use[11] = 3'b000; // all zero
        v_instr[12] = 32'h422081B3; v_op[12] = 10'h001; v_imm[12] = 32'h00000000; v_use[12] = 3'b111; // sub, funct7=0x21
        v_instr[13] = 32'h402081B3; v_op[13] = 10'h001; v_imm[13] = 32'h00000000; v_use[13] = 3'b111; // sub x3,x1,x2
        for (int i = 0; i < NV; i++) v_ill[i] = (i == 11) || (i == 12);
    endtask

    task automatic present(input int idx);
        logic [31:0] ins;
        ins = v_instr[idx];
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = next_pc;
        cur_exp.pc   = next_pc;
        cur_exp.op   = v_op[idx];
        cur_exp.rs1  = ins[19:15];
        cur_exp.rs2  = ins[24:20];
        cur_exp.rd   = ins[11:7];
        cur_exp.f3   = ins[14:12];
        cur_exp.f7   = ins[31:25];
        cur_exp.imm  = v_imm[idx];
        cur_exp.rs1u = v_use[idx][2];
        cur_exp.rs2u = v_use[idx][1];
`ifdef DECODE_ILLEGAL_CHECK_EN
        cur_exp.rdwr = v_use[idx][0] & ~v_ill[idx];
        cur_exp.ill  = v_ill[idx];
`else
        cur_exp.rdwr = v_use[idx][0];
        cur_exp.ill  = 1'b0;
`endif
        next_pc = next_pc + 32'd4;
    endtask

    // One clock: scoreboard work at the negedge, return just after the next posedge.
    task automatic step();
        exp_t e;
        exp_t act;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h with nothing expected", bus.out_pc);
            end else begin
                e = sb_q.pop_front();
                pops++;
                act = {bus.out_pc, bus.out_op, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_funct3,
                       bus.out_funct7, bus.out_imm, bus.out_rs1_used, bus.out_rs2_used,
                       bus.out_rd_wr, bus.out_illegal};
                if (act !== e) begin
                    bad++;
                    $display("FAIL sb_entry pc=%h: got %h, expected %h", e.pc, act, e);
                end
            end
        end
        last_acc = bus.in_valid & bus.in_ready;
        if (bus.flush) sb_q.delete();
        else if (last_acc) sb_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries still pending, expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
        total++;
        if ({bus.out_pc, bus.out_op, bus.out_imm, bus.out_rd, bus.out_rd_wr, bus.out_rs1_used, bus.out_illegal} !== '0) begin
            bad++; $display("FAIL reset_fields: op=%h imm=%h pc=%h, expected all 0", bus.out_op, bus.out_imm, bus.out_pc);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        present(0);
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid: got %b, expected 1", bus.out_valid); end
        total++; if (bus.out_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL latency_imm: got %h, expected ffffffff", bus.out_imm); end
        total++; if (bus.out_rd !== 5'd1) begin bad++; $display("FAIL latency_rd: got %0d, expected 1", bus.out_rd); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_drop: got %b, expected 0", bus.out_valid); end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            present(i);
            step();
            total++;
            if (last_acc !== 1'b1 || sb_q.size() > 1) begin
                bad++; $display("FAIL stream_rate idx=%0d: accepted=%b pending=%0d, expected 1 and <=1", i, last_acc, sb_q.size());
            end
        end
        bus.in_valid = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        int p0;
        logic [PC_W-1:0] pc_a;
        bool_wait: begin end
        p0 = pops;
        bus.out_ready = 1'b0;
        pc_a = next_pc;
        present(4); step();
        present(5); step();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
        present(6);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (last_acc !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== pc_a || bus.out_op !== 10'h001) begin
                bad++; $display("FAIL bp_hold cyc=%0d: acc=%b valid=%b pc=%h op=%h, expected 0 1 %h 001",
                                i, last_acc, bus.out_valid, bus.out_pc, bus.out_op, pc_a);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_acc) break;
        end
        total++; if (last_acc !== 1'b1) begin bad++; $display("FAIL bp_accept_c: got %b, expected 1", last_acc); end
        bus.in_valid = 1'b0;
        drain();
        total++; if (pops - p0 !== 3) begin bad++; $display("FAIL bp_count: got %0d transfers, expected 3", pops - p0); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        present(0); step();
        present(1); step();
        present(2); bus.flush = 1'b1; step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_full: valid=%b ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
        end
        present(3); step();
        present(9); bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        step(); step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_accept_dropped: valid=%b, expected 0", bus.out_valid); end
        bus.out_ready = 1'b1;
        present(7); step();
        bus.in_valid = 1'b0;
        drain();
    endtask

    task automatic test_illegal();
        logic exp_ill;
`ifdef DECODE_ILLEGAL_CHECK_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        bus.out_ready = 1'b1;
        present(11); step(); bus.in_valid = 1'b0;
        total++;
        if (bus.out_illegal !== exp_ill || bus.out_rd_wr !== 1'b0) begin
            bad++; $display("FAIL illegal_zero: ill=%b rd_wr=%b, expected %b 0", bus.out_illegal, bus.out_rd_wr, exp_ill);
        end
        step();
        present(12); step(); bus.in_valid = 1'b0;
        total++;
        if (bus.out_illegal !== exp_ill || bus.out_rd_wr !== ~exp_ill) begin
            bad++; $display("FAIL illegal_sub21: ill=%b rd_wr=%b, expected %b %b", bus.out_illegal, bus.out_rd_wr, exp_ill, ~exp_ill);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        present(0); step();
        present(1); step();
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid: valid=%b ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
        end
        sb_q.delete();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        step(); step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_survivor: valid=%b, expected 0", bus.out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        load_table();
        test_reset();
        test_latency();
        test_stream();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
